// File: rtl/clk_sel_seq_pkg.sv
// Shared types and helpers for the clock-select sequencer.
// Holds the FSM state encoding, counter widths and a clog2 helper used
// to size the select ports. No ports (package).
package clk_sel_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OFF  = 2'd1,
        ST_ON   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int CNT_W  = 8;
    localparam int WDOG_W = 16;

    // Ceiling log2 with a floor of 1 so a 2-channel build still gets a 1-bit select.
    function automatic int clog2_min1(input int n);
        int w;
        int p;
        w = 32'sd1;
        p = 32'sd2;
        while (p < n) begin
            w = w + 32'sd1;
            p = p * 32'sd2;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_sel_wdog.sv
// Switch watchdog for the clock-select sequencer.
// Counts clk cycles while run is high and raises timeout once LIMIT cycles
// have elapsed; dropping run clears both counter and flag.
// Ports: clk, rst_n (async, active-low), srst (sync soft reset),
//        run (count enable / clear when low), timeout (registered flag).
module clk_sel_wdog
    import clk_sel_seq_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic run,
    output logic timeout
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] cnt_r;
    logic              timeout_r;

    // Cycle counter with sticky timeout while run stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {WDOG_W{1'b0}};
            timeout_r <= 1'b0;
        end else if (srst || !run) begin
            cnt_r     <= {WDOG_W{1'b0}};
            timeout_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            timeout_r <= 1'b1;
        end else begin
            cnt_r <= cnt_r + WDOG_W'(1);
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/clk_sel_seq.sv
// Glitch-free clock-select sequencer: break-before-make switching between
// NCH gated clock channels with a dead gap and a settle interval.
// Optional watchdog under macro CLK_SEL_SEQ_WDOG_EN: aborts a switch whose
// target source is not alive and restores the previous channel.
// Ports: clk, rst_n (async active-low), srst (sync soft reset),
//        req_valid/req_sel/req_ready (switch request handshake),
//        alive (per-channel running level, watchdog build only),
//        ce (one-hot or zero enables), cur_sel, busy, done, err.
module clk_sel_seq
    import clk_sel_seq_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int SW         = clog2_min1(NCH),
    parameter int INIT_SEL   = 0,
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 2,
    parameter int WDOG_CYC   = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           srst,
    input  logic           req_valid,
    input  logic [SW-1:0]  req_sel,
`ifdef CLK_SEL_SEQ_WDOG_EN
    input  logic [NCH-1:0] alive,
`endif
    output logic           req_ready,
    output logic [NCH-1:0] ce,
    output logic [SW-1:0]  cur_sel,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam logic [NCH-1:0]   CE_ONE    = {{(NCH-1){1'b0}}, 1'b1};
    localparam logic [NCH-1:0]   CE_INIT   = CE_ONE << INIT_SEL;
    localparam logic [SW-1:0]    SEL_INIT  = SW'(INIT_SEL);
    localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam logic [SW:0]      NCH_LIM   = (SW+1)'(NCH);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [SW-1:0]     tgt_r, tgt_s;
    logic [SW-1:0]     prev_r, prev_s;
    logic [NCH-1:0]    ce_r, ce_s;
    logic [SW-1:0]     cur_sel_r, cur_sel_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              ready_r, ready_s;
    logic              busy_r, busy_s;
    logic              abort_r, abort_s;

    logic              acc_s, bad_s, same_s, cnt_zero_s;
    logic              wd_abort_s, alive_ok_s;

    assign acc_s      = req_valid & ready_r;
    assign bad_s      = ({1'b0, req_sel} >= NCH_LIM);
    assign same_s     = (req_sel == cur_sel_r);
    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

`ifdef CLK_SEL_SEQ_WDOG_EN
    logic wd_run_s, wd_timeout_s;

    // Watchdog runs from OFF entry until the switch finishes; the restore leg is not timed.
    assign wd_run_s   = ((state_r == ST_OFF) || (state_r == ST_ON)) && !abort_r;
    assign wd_abort_s = wd_timeout_s & ~alive[tgt_r] & ~abort_r;
    assign alive_ok_s = alive[tgt_r];

    clk_sel_wdog #(
        .LIMIT   (WDOG_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .srst    (srst),
        .run     (wd_run_s),
        .timeout (wd_timeout_s)
    );
`else
    logic [15:0] unused_wdog_s;

    assign unused_wdog_s = 16'(WDOG_CYC);
    assign wd_abort_s    = 1'b0;
    assign alive_ok_s    = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s && !bad_s && !same_s) begin
                    state_s = ST_OFF;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OFF: begin
                if (wd_abort_s) begin
                    state_s = ST_OFF;
                end else if (cnt_zero_s) begin
                    // The restore leg skips settling and reports straight from FIN.
                    state_s = abort_r ? ST_FIN : ST_ON;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_ON: begin
                if (wd_abort_s) begin
                    state_s = ST_OFF;
                end else if (cnt_zero_s && alive_ok_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_ON;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM datapath and output decode; all results land in registers.
    always_comb begin
        cnt_s     = cnt_r;
        tgt_s     = tgt_r;
        prev_s    = prev_r;
        ce_s      = ce_r;
        cur_sel_s = cur_sel_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        abort_s   = abort_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    if (bad_s) begin
                        err_s = 1'b1;
                    end else if (same_s) begin
                        done_s = 1'b1;
                    end else begin
                        tgt_s  = req_sel;
                        prev_s = cur_sel_r;
                        ce_s   = {NCH{1'b0}};
                        cnt_s  = DEAD_LD;
                    end
                end else begin
                    abort_s = 1'b0;
                end
            end
            ST_OFF: begin
                if (wd_abort_s) begin
                    tgt_s   = prev_r;
                    cnt_s   = DEAD_LD;
                    abort_s = 1'b1;
                end else if (cnt_zero_s) begin
                    ce_s      = CE_ONE << tgt_r;
                    cur_sel_s = tgt_r;
                    if (abort_r) begin
                        err_s = 1'b1;
                    end else begin
                        cnt_s = SETTLE_LD;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (wd_abort_s) begin
                    ce_s    = {NCH{1'b0}};
                    tgt_s   = prev_r;
                    cnt_s   = DEAD_LD;
                    abort_s = 1'b1;
                end else if (cnt_zero_s) begin
                    // Counter parks at zero while waiting for the target source.
                    done_s = alive_ok_s;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_FIN: begin
                abort_s = 1'b0;
            end
            default: begin
                abort_s = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
        busy_s  = (state_s != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            tgt_r     <= SEL_INIT;
            prev_r    <= SEL_INIT;
            ce_r      <= CE_INIT;
            cur_sel_r <= SEL_INIT;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            abort_r   <= 1'b0;
        end else if (srst) begin
            cnt_r     <= {CNT_W{1'b0}};
            tgt_r     <= SEL_INIT;
            prev_r    <= SEL_INIT;
            ce_r      <= CE_INIT;
            cur_sel_r <= SEL_INIT;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            tgt_r     <= tgt_s;
            prev_r    <= prev_s;
            ce_r      <= ce_s;
            cur_sel_r <= cur_sel_s;
            done_r    <= done_s;
            err_r     <= err_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            abort_r   <= abort_s;
        end
    end

    assign req_ready = ready_r;
    assign ce        = ce_r;
    assign cur_sel   = cur_sel_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_clk_sel_seq.sv
// Directed bench for clk_sel_seq: a 4-channel instance (DEAD 4, SETTLE 2,
// WDOG 16) and a 3-channel instance for out-of-range selects.
// Watchdog scenario is built when CLK_SEL_SEQ_WDOG_EN is defined.
module tb_clk_sel_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       srst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic [3:0] alive = 4'hF;
    logic       req_ready, busy, done, err;
    logic [3:0] ce;
    logic [1:0] cur_sel;

    logic       req_valid3 = 1'b0;
    logic [1:0] req_sel3 = 2'd0;
    logic [2:0] alive3 = 3'b111;
    logic       req_ready3, busy3, done3, err3;
    logic [2:0] ce3;
    logic [1:0] cur_sel3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_sel_seq #(
        .NCH(4), .INIT_SEL(0), .DEAD_CYC(4), .SETTLE_CYC(2), .WDOG_CYC(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .srst(srst),
        .req_valid(req_valid), .req_sel(req_sel),
`ifdef CLK_SEL_SEQ_WDOG_EN
        .alive(alive),
`endif
        .req_ready(req_ready), .ce(ce), .cur_sel(cur_sel),
        .busy(busy), .done(done), .err(err)
    );

    clk_sel_seq #(
        .NCH(3), .INIT_SEL(1), .DEAD_CYC(4), .SETTLE_CYC(2), .WDOG_CYC(16)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .srst(srst),
        .req_valid(req_valid3), .req_sel(req_sel3),
`ifdef CLK_SEL_SEQ_WDOG_EN
        .alive(alive3),
`endif
        .req_ready(req_ready3), .ce(ce3), .cur_sel(cur_sel3),
        .busy(busy3), .done(done3), .err(err3)
    );

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ce !== 4'b0001) begin failures++; $display("FAIL rst_ce got=%b exp=0001", ce); end
        checks++; if (cur_sel !== 2'd0) begin failures++; $display("FAIL rst_cur_sel got=%0d exp=0", cur_sel); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
        checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, done, err}); end
        checks++; if (ce3 !== 3'b010) begin failures++; $display("FAIL rst_ce3 got=%b exp=010", ce3); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rel_ready_early got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", req_ready); end
        checks++; if (ce !== 4'b0001) begin failures++; $display("FAIL rel_ce got=%b exp=0001", ce); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rel_busy got=%b exp=0", busy); end
        checks++; if (req_ready3 !== 1'b1) begin failures++; $display("FAIL rel_ready3 got=%b exp=1", req_ready3); end
    endtask

    task automatic test_switch();
        logic [3:0] exp_ce;
        logic [1:0] exp_sel;
        logic       exp_done, exp_busy;
        req_valid = 1'b1; req_sel = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            exp_ce   = (k <= 5) ? 4'b0000 : 4'b0100;
            exp_sel  = (k <= 5) ? 2'd0 : 2'd2;
            exp_done = (k == 9);
            exp_busy = (k <= 9);
            checks++; if (ce !== exp_ce) begin failures++; $display("FAIL sw_ce k=%0d got=%b exp=%b", k, ce, exp_ce); end
            checks++; if (cur_sel !== exp_sel) begin failures++; $display("FAIL sw_cur_sel k=%0d got=%0d exp=%0d", k, cur_sel, exp_sel); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL sw_done k=%0d got=%b exp=%b", k, done, exp_done); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL sw_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
            checks++; if (req_ready !== !exp_busy) begin failures++; $display("FAIL sw_ready k=%0d got=%b exp=%b", k, req_ready, !exp_busy); end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL sw_err k=%0d got=%b exp=0", k, err); end
            @(negedge clk);
        end
    endtask

    task automatic test_same_sel();
        req_valid = 1'b1; req_sel = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL same_done got=%b exp=1", done); end
        checks++; if (ce !== 4'b0100) begin failures++; $display("FAIL same_ce got=%b exp=0100", ce); end
        checks++; if ({busy, req_ready} !== 2'b01) begin failures++; $display("FAIL same_idle got=%b exp=01", {busy, req_ready}); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL same_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_bad_sel();
        req_valid3 = 1'b1; req_sel3 = 2'd3;
        @(negedge clk);
        req_valid3 = 1'b0;
        checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", err3); end
        checks++; if (ce3 !== 3'b010) begin failures++; $display("FAIL bad_ce got=%b exp=010", ce3); end
        checks++; if (cur_sel3 !== 2'd1) begin failures++; $display("FAIL bad_cur_sel got=%0d exp=1", cur_sel3); end
        checks++; if ({busy3, done3, req_ready3} !== 3'b001) begin failures++; $display("FAIL bad_flags got=%b exp=001", {busy3, done3, req_ready3}); end
        @(negedge clk);
        checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL bad_err_pulse got=%b exp=0", err3); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ce;
        req_valid = 1'b1; req_sel = 2'd1;
        @(negedge clk);
        req_sel = 2'd3;
        for (int k = 1; k <= 9; k++) begin
            exp_ce = (k <= 5) ? 4'b0000 : 4'b0010;
            checks++; if (ce !== exp_ce) begin failures++; $display("FAIL b2b1_ce k=%0d got=%b exp=%b", k, ce, exp_ce); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b1_ready k=%0d got=%b exp=0", k, req_ready); end
            checks++; if (done !== (k == 9)) begin failures++; $display("FAIL b2b1_done k=%0d got=%b exp=%b", k, done, (k == 9)); end
            @(negedge clk);
        end
        checks++; if ({req_ready, cur_sel} !== 3'b101) begin failures++; $display("FAIL b2b_idle got=%b exp=101", {req_ready, cur_sel}); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            exp_ce = (k <= 5) ? 4'b0000 : 4'b1000;
            checks++; if (ce !== exp_ce) begin failures++; $display("FAIL b2b2_ce k=%0d got=%b exp=%b", k, ce, exp_ce); end
            checks++; if (done !== (k == 9)) begin failures++; $display("FAIL b2b2_done k=%0d got=%b exp=%b", k, done, (k == 9)); end
            @(negedge clk);
        end
        checks++; if (cur_sel !== 2'd3) begin failures++; $display("FAIL b2b2_cur_sel got=%0d exp=3", cur_sel); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_sel = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (ce !== 4'b0000) begin failures++; $display("FAIL mid_off_ce got=%b exp=0000", ce); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ce !== 4'b0001) begin failures++; $display("FAIL mid_rst_ce got=%b exp=0001", ce); end
        checks++; if (cur_sel !== 2'd0) begin failures++; $display("FAIL mid_rst_cur_sel got=%0d exp=0", cur_sel); end
        checks++; if ({busy, req_ready} !== 2'b00) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00", {busy, req_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done k=%0d got=%b exp=0", k, done); end
            checks++; if (ce !== 4'b0001) begin failures++; $display("FAIL mid_ce k=%0d got=%b exp=0001", k, ce); end
            checks++; if ({busy, req_ready} !== 2'b01) begin failures++; $display("FAIL mid_idle k=%0d got=%b exp=01", k, {busy, req_ready}); end
        end
    endtask

`ifdef CLK_SEL_SEQ_WDOG_EN
    task automatic test_wdog();
        int err_k;
        int done_seen;
        err_k = -1;
        done_seen = 0;
        alive = 4'b1011;
        req_valid = 1'b1; req_sel = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (err === 1'b1 && err_k < 0) err_k = k;
            if (done === 1'b1) done_seen++;
            if (k == 6) begin
                checks++; if (ce !== 4'b0100) begin failures++; $display("FAIL wd_on_ce got=%b exp=0100", ce); end
            end
            if (k == 18) begin
                checks++; if (ce !== 4'b0000) begin failures++; $display("FAIL wd_gap_ce got=%b exp=0000", ce); end
            end
            if (k == 23) begin
                checks++; if (ce !== 4'b0001) begin failures++; $display("FAIL wd_restore_ce got=%b exp=0001", ce); end
                checks++; if (cur_sel !== 2'd0) begin failures++; $display("FAIL wd_cur_sel got=%0d exp=0", cur_sel); end
            end
            @(negedge clk);
        end
        checks++; if (err_k != 23) begin failures++; $display("FAIL wd_err_cycle got=%0d exp=23", err_k); end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL wd_no_done got=%0d exp=0", done_seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_idle got=%b exp=0", busy); end
        alive = 4'hF;
    endtask
`endif

    task automatic test_random();
        int bad4;
        int bad3;
        bad4 = 0;
        bad3 = 0;
        for (int k = 0; k < 10000; k++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_sel    = 2'($urandom_range(0, 3));
            req_valid3 = 1'($urandom_range(0, 1));
            req_sel3   = 2'($urandom_range(0, 3));
            @(negedge clk);
            if ($countones(ce) > 1) bad4++;
            if ($countones(ce3) > 1) bad3++;
        end
        req_valid = 1'b0;
        req_valid3 = 1'b0;
        checks++; if (bad4 != 0) begin failures++; $display("FAIL rand_onehot4 got=%0d exp=0 bad cycles", bad4); end
        checks++; if (bad3 != 0) begin failures++; $display("FAIL rand_onehot3 got=%0d exp=0 bad cycles", bad3); end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_sel();
        test_bad_sel();
        test_back_to_back();
        test_reset_mid();
`ifdef CLK_SEL_SEQ_WDOG_EN
        test_wdog();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_sel_seq.md
CLK_SEL_SEQ -- requirements
Module: clk_sel_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of clock channels (2..16).
REQ-002 SHALL have parameter SW, default 2, select width; SW = clog2(NCH) (min 1).
REQ-003 SHALL have parameter INIT_SEL, default 0, channel enabled out of reset (< NCH).
REQ-004 SHALL have parameter DEAD_CYC, default 4, break-before-make gap in clk cycles (0..255).
REQ-005 SHALL have parameter SETTLE_CYC, default 2, post-enable settle in clk cycles (0..255).
REQ-006 SHALL have parameter WDOG_CYC, default 64, watchdog limit in clk cycles (1..65535); used only under CLK_SEL_SEQ_WDOG_EN.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 req_valid  in  1  switch request.
REQ-010 req_sel  in  SW  target channel.
REQ-011 req_ready  out  1  high in IDLE only; transfer on req_valid & req_ready.
REQ-012 ce  out  NCH  per-channel clock enable, one-hot or all-zero.
REQ-013 cur_sel  out  SW  channel currently enabled or last enabled.
REQ-014 busy  out  1  high whenever FSM not IDLE.
REQ-015 done  out  1  one-cycle pulse when a switch completes.
REQ-016 err  out  1  one-cycle pulse on rejected request or watchdog abort.
REQ-017 alive  in  NCH  per-channel source-running level, already synchronised to clk; present only under CLK_SEL_SEQ_WDOG_EN.

Function
REQ-018 FSM states SHALL be IDLE, OFF, ON, FIN.
REQ-019 IDLE: accepted request with req_sel >= NCH SHALL pulse err next cycle, stay IDLE, leave ce unchanged.
REQ-020 IDLE: accepted request with req_sel == cur_sel SHALL pulse done next cycle, stay IDLE, no ce change.
REQ-021 IDLE: any other accepted request SHALL latch target, clear ce to zero next cycle, load counter = DEAD_CYC, go OFF.
REQ-022 OFF: counter SHALL decrement each cycle; at 0, ce[target] SHALL assert next cycle, cur_sel = target, counter = SETTLE_CYC, go ON.
REQ-023 ON: counter SHALL decrement; at 0 go FIN; FIN SHALL pulse done for one cycle and return to IDLE.
REQ-024 Latency accept->ce[target] high SHALL be DEAD_CYC+2 cycles; accept->done SHALL be DEAD_CYC+SETTLE_CYC+3 cycles.
REQ-025 ce SHALL never have more than one bit set in any cycle, including reset exit.
REQ-026 req_valid while busy SHALL be ignored (req_ready low); requester holds request.
REQ-027 Counter SHALL be 8 bits; no wrap: decrement stops at 0.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, ce = one-hot INIT_SEL, cur_sel = INIT_SEL, counter 0, done/err 0, busy 0, req_ready 0 while asserted.
REQ-029 Reset asserted mid-switch SHALL abandon the switch; no done pulse after release.
REQ-030 req_ready SHALL rise the first clk edge after rst_n release.

Configuration
REQ-031 Macro CLK_SEL_SEQ_WDOG_EN defined: alive port present; 16-bit watchdog counts from entry to OFF; if alive[target] not high by end of ON within WDOG_CYC cycles, SHALL clear ce, restore previous channel after DEAD_CYC, pulse err (no done), return IDLE.
REQ-032 Macro undefined: alive port and watchdog absent; err only from REQ-019.

Structure
REQ-033 Package clk_sel_seq_pkg SHALL hold state enum, counter widths, clog2 function.
REQ-034 Watchdog SHALL be sub-module clk_sel_wdog (counter + timeout flag), instantiated only under the macro.

Verification
REQ-035 Reset release, INIT_SEL=0 -> ce=4'b0001, cur_sel=0, req_ready=1 one cycle after release.
REQ-036 Request sel=2, DEAD_CYC=4, SETTLE_CYC=2 -> ce=0 for 5 cycles, ce=4'b0100 at +6, done at +9.
REQ-037 Request sel=cur_sel -> done next cycle, ce unchanged; NCH=3, request sel=3 -> err, ce unchanged.
REQ-038 rst_n low during OFF -> ce=one-hot INIT_SEL immediately, no done after release.
REQ-039 WDOG_EN, WDOG_CYC=16, alive[2]=0, switch 0->2 -> err at timeout, ce returns 4'b0001, cur_sel=0.
REQ-040 Random request streams, 10k cycles -> ce always one-hot or zero, never two bits set.
